// File: rtl/instr_mem_arbiter.sv
// instr_mem_arbiter
//   Round-robin arbiter that lets num_cores_p cores share one instruction
//   memory port with exactly one transaction outstanding at a time.
//   Optional per-core grant counters are built when ARB_PERF_CNT_EN is
//   defined; otherwise grant_count_o is tied to zero.
//
// Ports
//   clk_i, nreset_i           clock, synchronous active-low reset
//   core_valid_i/core_ready_o per-core fetch request handshake
//   core_addr_i               per-core fetch address
//   core_valid_o/core_rdata_o per-core response (one-cycle pulse)
//   mem_valid_o/mem_ready_i   request handshake to shared memory
//   mem_addr_o                registered request address
//   mem_valid_i/mem_rdata_i   memory response
//   grant_count_o             per-core grant counters (saturating)
module instr_mem_arbiter #(
  parameter int unsigned num_cores_p  = 2,
  parameter int unsigned addr_width_p = 32
) (
  input  logic                                       clk_i,
  input  logic                                       nreset_i,
  input  logic [num_cores_p-1:0]                     core_valid_i,
  output logic [num_cores_p-1:0]                     core_ready_o,
  input  logic [num_cores_p-1:0][addr_width_p-1:0]   core_addr_i,
  output logic [num_cores_p-1:0]                     core_valid_o,
  output logic [num_cores_p-1:0][31:0]               core_rdata_o,
  output logic                                       mem_valid_o,
  input  logic                                       mem_ready_i,
  output logic [addr_width_p-1:0]                    mem_addr_o,
  input  logic                                       mem_valid_i,
  input  logic [31:0]                                mem_rdata_i,
  output logic [num_cores_p-1:0][31:0]               grant_count_o
);

  localparam int unsigned IdxW = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  typedef logic [IdxW-1:0] idx_t;

  logic [1:0]              state_q, state_d;
  idx_t                    rr_ptr_q, rr_ptr_d;
  idx_t                    owner_q, owner_d;
  logic [addr_width_p-1:0] addr_q, addr_d;

  logic grant_vld;
  idx_t grant_idx;

  // Scan cores starting at rr_ptr and wrapping; first requester wins.
  always_comb begin : pick
    int unsigned cand;
    idx_t        cand_idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < num_cores_p; i++) begin
      cand     = (32'(rr_ptr_q) + i) % num_cores_p;
      cand_idx = idx_t'(cand);
      if (!grant_vld && core_valid_i[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d  = ISSUE;
          owner_d  = grant_idx;
          addr_d   = core_addr_i[grant_idx];
          rr_ptr_d = idx_t'((32'(grant_idx) + 32'd1) % num_cores_p);
        end
      end
      ISSUE: if (mem_ready_i) state_d = WAIT;
      WAIT:  if (mem_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs are forced low while reset is asserted, even before the
  // first clock edge has cleared the state registers.
  always_comb begin : outputs
    core_ready_o = '0;
    core_valid_o = '0;
    core_rdata_o = '0;
    mem_valid_o  = 1'b0;
    if (nreset_i) begin
      case (state_q)
        IDLE:  if (grant_vld) core_ready_o[grant_idx] = 1'b1;
        ISSUE: mem_valid_o = 1'b1;
        WAIT: begin
          core_valid_o[owner_q] = mem_valid_i;
          core_rdata_o[owner_q] = mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_o = nreset_i ? addr_q : '0;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [num_cores_p-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && grant_vld && cnt_q[grant_idx] != '1)
      cnt_d[grant_idx] = cnt_q[grant_idx] + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign grant_count_o = nreset_i ? cnt_q : '0;
`else
  assign grant_count_o = '0;
`endif

endmodule

// File: tb/tb_instr_mem_arbiter.sv
module tb_instr_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;

  logic                   clk_i = 1'b0;
  logic                   nreset_i;
  logic [N-1:0]           core_valid_i;
  logic [N-1:0]           core_ready_o;
  logic [N-1:0][AW-1:0]   core_addr_i;
  logic [N-1:0]           core_valid_o;
  logic [N-1:0][31:0]     core_rdata_o;
  logic                   mem_valid_o;
  logic                   mem_ready_i;
  logic [AW-1:0]          mem_addr_o;
  logic                   mem_valid_i;
  logic [31:0]            mem_rdata_i;
  logic [N-1:0][31:0]     grant_count_o;

  instr_mem_arbiter #(.num_cores_p(N), .addr_width_p(AW)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .core_addr_i(core_addr_i),
    .core_valid_o(core_valid_o), .core_rdata_o(core_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o),
    .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
    .grant_count_o(grant_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  // Transaction-level reference: is a fetch outstanding, has memory taken it,
  // who owns it, and where the round-robin search starts next.
  bit          m_busy  = 0;
  bit          m_sent  = 0;
  int          m_owner = 0;
  int          m_next  = 0;
  logic [31:0] m_addr  = '0;
  longint      m_cnt [N];
  int          g_obs[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_next + k) % N]) return (m_next + k) % N;
    end
    return -1;
  endfunction

  task automatic cyc(input logic nrst, input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                     input logic mr, input logic mv, input logic [31:0] rd);
    logic [N-1:0]       e_rdy, e_cv;
    logic [N-1:0][31:0] e_rd, e_cnt;
    logic               e_mv;
    logic [AW-1:0]      e_ma;
    int                 w;
    nreset_i = nrst; core_valid_i = v; core_addr_i = a;
    mem_ready_i = mr; mem_valid_i = mv; mem_rdata_i = rd;
    @(negedge clk_i);
    e_rdy = '0; e_cv = '0; e_rd = '0; e_cnt = '0; e_mv = 1'b0; e_ma = '0;
    w = winner(v);
    if (nrst) begin
      if (!m_busy && w >= 0) e_rdy[w] = 1'b1;
      e_mv = m_busy && !m_sent;
      e_ma = m_addr;
      if (m_busy && m_sent) begin
        e_cv[m_owner] = mv;
        e_rd[m_owner] = rd;
      end
`ifdef ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) e_cnt[i] = 32'(m_cnt[i]);
`endif
    end
    chk("core_ready", 64'(core_ready_o), 64'(e_rdy));
    chk("mem_valid", 64'(mem_valid_o), 64'(e_mv));
    chk("mem_addr", 64'(mem_addr_o), 64'(e_ma));
    chk("core_valid", 64'(core_valid_o), 64'(e_cv));
    chk("core_rdata", 64'(core_rdata_o), 64'(e_rd));
    chk("grant_count", 64'(grant_count_o), 64'(e_cnt));
    for (int i = 0; i < N; i++) if (core_ready_o[i]) g_obs.push_back(i);
    @(posedge clk_i);
    if (!nrst) begin
      m_busy = 0; m_sent = 0; m_owner = 0; m_next = 0; m_addr = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_sent = 0; m_owner = w; m_addr = a[w]; m_next = (w + 1) % N;
        if (m_cnt[w] < 64'hFFFF_FFFF) m_cnt[w]++;
      end
    end else if (!m_sent) begin
      if (mr) m_sent = 1;
    end else if (mv) begin
      m_busy = 0;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Grant, accepted issue, one-cycle response.
  task automatic txn(input int c, input logic [31:0] addr, input logic [31:0] rd);
    logic [N-1:0][AW-1:0] a;
    logic [N-1:0]         v;
    a = '0; v = '0;
    a[c] = addr; v[c] = 1'b1;
    cyc(1'b1, v, a, 1'b0, 1'b0, '0);
    cyc(1'b1, '0, a, 1'b1, 1'b0, '0);
    cyc(1'b1, '0, a, 1'b0, 1'b1, rd);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    nreset_i = 1'b0; core_valid_i = '0; core_addr_i = '0;
    mem_ready_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = '0;

    // Single request, response three cycles after the grant.
    do_reset(2);
    cyc(1'b1, 2'b01, {32'h0, 32'h0000_0040}, 1'b1, 1'b0, '0);
    cyc(1'b1, 2'b00, '0, 1'b1, 1'b0, '0);
    cyc(1'b1, 2'b00, '0, 1'b1, 1'b0, '0);
    cyc(1'b1, 2'b00, '0, 1'b1, 1'b1, 32'h0000_0013);
    cyc(1'b1, 2'b00, '0, 1'b1, 1'b0, '0);

    // Both cores hold valid; memory always ready and always responding.
    do_reset(1);
    g_obs.delete();
    for (int i = 0; i < 18; i++)
      cyc(1'b1, 2'b11, {32'h0000_2000 + 32'(i), 32'h0000_1000 + 32'(i)}, 1'b1, 1'b1, $urandom);
    chk("rr_count", 64'(g_obs.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      if (k < g_obs.size()) chk("rr_seq", 64'(g_obs[k]), 64'(k % 2));

    // Backpressure in ISSUE for four cycles.
    do_reset(1);
    cyc(1'b1, 2'b10, {32'h0000_0880, 32'h0}, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b11, {32'h1, 32'h2}, 1'b0, 1'b0, '0);
    cyc(1'b1, 2'b11, {32'h3, 32'h4}, 1'b1, 1'b0, '0);
    cyc(1'b1, 2'b00, '0, 1'b0, 1'b1, 32'h1234_5678);

    // Spurious response while idle, then a request still granted at once.
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, '0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    txn(1, 32'h0000_0100, 32'h0000_00AA);

    // Reset while waiting for the response; late response must be dropped.
    do_reset(1);
    cyc(1'b1, 2'b10, {32'h0000_0200, 32'h0}, 1'b1, 1'b0, '0);
    cyc(1'b1, 2'b00, '0, 1'b1, 1'b0, '0);
    do_reset(1);
    cyc(1'b1, 2'b00, '0, 1'b1, 1'b1, 32'hCAFE_F00D);
    g_obs.delete();
    cyc(1'b1, 2'b11, {32'h0000_0300, 32'h0000_0304}, 1'b1, 1'b0, '0);
    chk("post_reset_grant_cnt", 64'(g_obs.size()), 64'd1);
    if (g_obs.size() > 0) chk("post_reset_grant", 64'(g_obs[0]), 64'd0);
    cyc(1'b1, 2'b00, '0, 1'b1, 1'b0, '0);
    cyc(1'b1, 2'b00, '0, 1'b0, 1'b1, 32'h0000_0055);

    // Grant counters: five grants to core 0, three to core 1.
    do_reset(1);
    for (int i = 0; i < 5; i++) txn(0, 32'h0000_4000 + 32'(4 * i), $urandom);
    for (int i = 0; i < 3; i++) txn(1, 32'h0000_8000 + 32'(4 * i), $urandom);
`ifdef ARB_PERF_CNT_EN
    chk("perf_counts", 64'(grant_count_o), {32'd3, 32'd5});
`else
    chk("perf_counts", 64'(grant_count_o), 64'd0);
`endif

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 500; i++)
      cyc(($urandom_range(0, 49) != 0), N'($urandom), {$urandom, $urandom},
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/instr_mem_arbiter.md
INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

Interface
REQ-001 SHALL have parameter num_cores_p, default 2: number of requesting cores; legal values 1..8.
REQ-002 SHALL have parameter addr_width_p, default 32: request address width.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nreset_i, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port core_valid_i, input, [num_cores_p-1:0]: per-core fetch request valid.
REQ-006 SHALL have port core_ready_o, output, [num_cores_p-1:0]: per-core request accepted this cycle.
REQ-007 SHALL have port core_addr_i, input, [num_cores_p-1:0][addr_width_p-1:0]: per-core fetch address.
REQ-008 SHALL have port core_valid_o, output, [num_cores_p-1:0]: per-core response valid, one-cycle pulse.
REQ-009 SHALL have port core_rdata_o, output, [num_cores_p-1:0][31:0]: per-core response word.
REQ-010 SHALL have port mem_valid_o, output, 1: request valid to the shared instruction memory.
REQ-011 SHALL have port mem_ready_i, input, 1: memory accepts the request when high with mem_valid_o.
REQ-012 SHALL have port mem_addr_o, output, [addr_width_p-1:0]: registered request address.
REQ-013 SHALL have port mem_valid_i, input, 1: memory response valid.
REQ-014 SHALL have port mem_rdata_i, input, 32: memory response word.
REQ-015 SHALL have port grant_count_o, output, [num_cores_p-1:0][31:0]: per-core grant counters (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT; exactly one memory transaction outstanding.
REQ-017 In IDLE with any core_valid_i high, SHALL grant the first requesting core at or after rr_ptr (round-robin, wrapping num_cores_p-1 -> 0), assert that core's core_ready_o combinationally, capture its address and index into owner_r, and go to ISSUE.
REQ-018 At most one core_ready_o bit SHALL be high per cycle; core_ready_o SHALL be all-zero outside IDLE.
REQ-019 On grant, rr_ptr SHALL become owner+1 modulo num_cores_p.
REQ-020 In ISSUE, mem_valid_o SHALL be 1 with mem_addr_o stable; on mem_valid_o & mem_ready_i, go to WAIT; mem_valid_o SHALL be 0 in IDLE and WAIT.
REQ-021 In WAIT, core_valid_o[owner_r] SHALL equal mem_valid_i and core_rdata_o[owner_r] SHALL equal mem_rdata_i (combinational); on mem_valid_i, go to IDLE.
REQ-022 core_rdata_o for non-owner cores SHALL be 0; core_valid_o SHALL be all-zero outside WAIT.
REQ-023 mem_valid_i in IDLE or ISSUE SHALL be ignored (no core_valid_o, no state change).
REQ-024 Minimum latency: grant cycle N, mem_valid_o cycle N+1, earliest next grant one cycle after the response cycle.
REQ-025 With num_cores_p=1 the arbiter SHALL degenerate to a single-owner pass-through with the same FSM timing.

Reset
REQ-026 While nreset_i is low at a clock edge: state=IDLE, rr_ptr=0, owner_r=0, mem_addr_o=0, counters=0.
REQ-027 During reset all outputs SHALL be 0 (core_ready_o, core_valid_o, mem_valid_o included).
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; a late mem_valid_i after reset SHALL be ignored per REQ-023.

Configuration
REQ-029 Macro ARB_PERF_CNT_EN defined: grant_count_o[i] SHALL increment by 1 on each grant to core i, saturating at 32'hFFFFFFFF.
REQ-030 Macro ARB_PERF_CNT_EN undefined: no counter flops SHALL be built; grant_count_o SHALL be tied to 0.

Verification
REQ-031 Single request: core 0 addr 32'h0000_0040, mem_ready_i=1, response 3 cycles later rdata 32'h0000_0013 -> core_ready_o=2'b01 cycle 0, mem_valid_o cycle 1 addr 0x40, core_valid_o[0] with 0x13, core 1 sees nothing.
REQ-032 Simultaneous requests, rr_ptr=0, both cores hold valid -> grants core 0 then core 1 then core 0, alternating for 6 grants.
REQ-033 Backpressure: mem_ready_i low 4 cycles in ISSUE -> mem_valid_o held 5 cycles, mem_addr_o constant, no core_ready_o.
REQ-034 Spurious mem_valid_i=1 in IDLE with rdata 32'hDEAD_BEEF -> core_valid_o stays 0, state stays IDLE.
REQ-035 Reset asserted in WAIT, then mem_valid_i one cycle after release -> no core_valid_o, next grant goes to core 0.
REQ-036 With ARB_PERF_CNT_EN: 5 grants core 0, 3 grants core 1 -> grant_count_o = {3, 5}; without macro -> {0, 0}.
